// File: rtl/rc4_encryptor.sv
// RC4 stream encryptor: INIT/KSA/PRGA over an external 256x8 S RAM, byte-wise XOR with ready/valid.
// Define RC4_ENC_KEY_MASK_EN to clear the top two key bits (22-bit effective key space).
module rc4_encryptor #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [5:0]             msg_len,
  input  logic [7:0]             pt_data,
  input  logic                   pt_valid,
  output logic                   pt_ready,
  output logic [7:0]             ct_data,
  output logic                   ct_valid,
  input  logic                   ct_ready,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic                   busy,
  output logic                   done
);
  localparam int KEYW = 8 * KEY_BYTES;
  localparam int KW   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_KSA, ST_PRGA, ST_XOR, ST_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [7:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, k_q, k_d;
  logic [2:0]      ph_q, ph_d;
  logic [KW-1:0]   kidx_q, kidx_d;
  logic [KEYW-1:0] key_q, key_d, key_eff;
  logic [5:0]      len_q, len_d, cnt_q, cnt_d;
  logic [7:0]      ct_data_q, ct_data_d;
  logic            ct_valid_q, ct_valid_d, done_q, done_d;
  logic [7:0]      kbyte;

`ifdef RC4_ENC_KEY_MASK_EN
  assign key_eff = secret_key & ~(KEYW'(3) << (KEYW - 2));
`else
  assign key_eff = secret_key;
`endif

  // key byte 0 sits in the most significant byte
  assign kbyte    = 8'(key_q >> (8 * (KEY_BYTES - 1 - int'(kidx_q))));
  assign ct_data  = ct_data_q;
  assign ct_valid = ct_valid_q;
  assign done     = done_q;
  assign busy     = (state_q != ST_IDLE) || done_q;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    ph_d       = ph_q;
    kidx_d     = kidx_q;
    key_d      = key_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ct_data_d  = ct_data_q;
    ct_valid_d = ct_valid_q;
    done_d     = 1'b0;
    s_address  = 8'd0;
    s_data     = 8'd0;
    s_wren     = 1'b0;
    pt_ready   = 1'b0;

    if (ct_valid_q && ct_ready) ct_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          state_d = ST_INIT;
          key_d   = key_eff;
          len_d   = msg_len;
          i_d     = 8'd0;
          j_d     = 8'd0;
          cnt_d   = 6'd0;
          ph_d    = 3'd0;
          kidx_d  = '0;
        end
      end
      ST_INIT: begin
        s_address = i_q;
        s_data    = i_q;
        s_wren    = 1'b1;
        i_d       = i_q + 8'd1;
        if (i_q == 8'd255) state_d = ST_KSA;
      end
      ST_KSA: begin
        ph_d = (ph_q == 3'd5) ? 3'd0 : ph_q + 3'd1;
        case (ph_q)
          3'd0: s_address = i_q;
          3'd1: begin
            si_d = s_q;
            j_d  = j_q + s_q + kbyte;
          end
          3'd2: s_address = j_q;
          3'd3: sj_d = s_q;
          3'd4: begin
            s_address = i_q;
            s_data    = sj_q;
            s_wren    = 1'b1;
          end
          default: begin
            s_address = j_q;
            s_data    = si_q;
            s_wren    = 1'b1;
            i_d       = i_q + 8'd1;
            kidx_d    = (kidx_q == KW'(KEY_BYTES - 1)) ? '0 : kidx_q + KW'(1);
            if (i_q == 8'd255) begin
              j_d = 8'd0;
              if (len_q == 6'd0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_PRGA;
              end
            end
          end
        endcase
      end
      ST_PRGA: begin
        // S[i]=S[j] is written in the cycle S[j] arrives, saving one cycle per byte
        ph_d = ph_q + 3'd1;
        case (ph_q)
          3'd0: begin
            s_address = i_q + 8'd1;
            i_d       = i_q + 8'd1;
          end
          3'd1: begin
            si_d = s_q;
            j_d  = j_q + s_q;
          end
          3'd2: s_address = j_q;
          3'd3: begin
            sj_d      = s_q;
            s_address = i_q;
            s_data    = s_q;
            s_wren    = 1'b1;
          end
          3'd4: begin
            s_address = j_q;
            s_data    = si_q;
            s_wren    = 1'b1;
          end
          3'd5: s_address = si_q + sj_q;
          default: begin
            k_d     = s_q;
            ph_d    = 3'd0;
            state_d = ST_XOR;
          end
        endcase
      end
      ST_XOR: begin
        pt_ready = !ct_valid_q || ct_ready;
        if (pt_valid && pt_ready) begin
          ct_data_d  = pt_data ^ k_q;
          ct_valid_d = 1'b1;
          cnt_d      = cnt_q + 6'd1;
          state_d    = (cnt_q + 6'd1 == len_q) ? ST_DRAIN : ST_PRGA;
        end
      end
      ST_DRAIN: begin
        if (!ct_valid_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      si_q       <= 8'd0;
      sj_q       <= 8'd0;
      k_q        <= 8'd0;
      ph_q       <= 3'd0;
      kidx_q     <= '0;
      key_q      <= '0;
      len_q      <= 6'd0;
      cnt_q      <= 6'd0;
      ct_data_q  <= 8'd0;
      ct_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      ph_q       <= ph_d;
      kidx_q     <= kidx_d;
      key_q      <= key_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      ct_data_q  <= ct_data_d;
      ct_valid_q <= ct_valid_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: doc/rc4_encryptor.md
RC4_ENCRYPTOR -- requirements
Module: rc4_encryptor

Interface
REQ-001 Parameter: KEY_BYTES, 3, number of secret-key bytes cycled during the KSA.
REQ-002 Port: clk  in  1  system clock; all state on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle pulse; begins an encryption run when idle.
REQ-005 Port: secret_key  in  24  key; byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0]; sampled on accepted start.
REQ-006 Port: msg_len  in  6  plaintext byte count, 0..63; sampled on accepted start.
REQ-007 Port: pt_data / pt_valid  in  8 / 1  plaintext byte stream.
REQ-008 Port: pt_ready  out  1  plaintext byte accepted when pt_valid & pt_ready.
REQ-009 Port: ct_data / ct_valid  out  8 / 1  ciphertext byte stream.
REQ-010 Port: ct_ready  in  1  ciphertext byte taken when ct_valid & ct_ready.
REQ-011 Port: s_address / s_data / s_wren  out  8 / 8 / 1  external 256x8 S RAM port.
REQ-012 Port: s_q  in  8  S RAM read data, valid one cycle after s_address is presented.
REQ-013 Port: busy / done  out  1 / 1  run in progress; one-cycle completion pulse.

Function
REQ-014 start is accepted only in IDLE; start while busy=1 shall be ignored.
REQ-015 States: IDLE -> INIT -> KSA -> PRGA -> XOR -> (PRGA | DRAIN) -> IDLE.
REQ-016 INIT: write S[n]=n for n=0..255, one write per cycle, exactly 256 cycles.
REQ-017 KSA: for i=0..255, j = (j + S[i] + key[i mod KEY_BYTES]) mod 256, then swap S[i] and S[j]; j starts at 0.
REQ-018 KSA swap timing: each step issues the S[i] read, waits one cycle, issues the S[j] read, waits one cycle, then performs two write cycles; 6 cycles per step.
REQ-019 PRGA: i=(i+1) mod 256, j=(j+S[i]) mod 256, swap S[i]/S[j], read S[(S[i]+S[j]) mod 256] as keystream byte k; i and j restart at 0 after KSA.
REQ-020 All index/sum arithmetic is 8-bit with natural wrap; no carries retained.
REQ-021 XOR: pt_ready = (!ct_valid | ct_ready); on pt handshake, ct_data <= pt_data ^ k, ct_valid <= 1, byte count increments.
REQ-022 ct_valid/ct_data hold stable until ct_ready; a simultaneous output take and new load keeps ct_valid=1 with the new byte.
REQ-023 After msg_len bytes are consumed, enter DRAIN; when ct_valid=0, pulse done for one cycle, return to IDLE.
REQ-024 msg_len=0: skip PRGA/XOR entirely; done pulses on the cycle after KSA completes.
REQ-025 pt_ready=0 outside XOR; s_wren=1 only during INIT and swap-write cycles.
REQ-026 busy=1 from the cycle after an accepted start until the done cycle inclusive.
REQ-027 Latency start -> first pt_ready <= 256 + 6*256 + 8 cycles.

Reset
REQ-028 reset asserted at any time shall immediately force IDLE, i=j=0, byte count=0.
REQ-029 Reset values: pt_ready=0, ct_valid=0, ct_data=0, s_wren=0, s_address=0, s_data=0, busy=0, done=0.
REQ-030 A run interrupted by reset is abandoned; no partial done pulse; the next start reruns INIT.

Configuration
REQ-031 Macro RC4_ENC_KEY_MASK_EN defined: effective key = {2'b00, secret_key[21:0]}, matching the 22-bit brute-force key space.
REQ-032 Macro RC4_ENC_KEY_MASK_EN undefined: all 24 secret_key bits are used unmodified.

Verification
REQ-033 Mask macro undefined, key 0x4B6579, msg_len 9, plaintext "Plaintext" -> ct bytes BB F3 16 E8 D9 40 AF 0A D3, then one done pulse.
REQ-034 Same run with ct_ready toggled 1/0 every cycle -> identical ct sequence; no byte lost or duplicated; ct_data stable while ct_valid & !ct_ready.
REQ-035 Mask macro defined, key 0xCB6579 -> ct identical to the run with key 0x0B6579 (macro undefined).
REQ-036 msg_len 0 -> pt_ready never asserts; done pulses once after INIT+KSA (1792 cycles + overhead).
REQ-037 reset pulsed mid-KSA -> all outputs zero next cycle; a fresh start with key 0x4B6579 reproduces REQ-033 output.
REQ-038 start pulsed during XOR -> ignored; ct stream and byte count unaffected.
